// File: rtl/dmem_pkg.sv
// Shared types and access-decode helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} acc_size_e;

  // Illegal encodings fall through to a word access.
  function automatic acc_size_e access_size(logic we, logic [2:0] f3);
    acc_size_e sz;
    sz = SzWord;
    case (funct3_e'(f3))
      F3_B:    sz = SzByte;
      F3_H:    sz = SzHalf;
      F3_BU:   sz = we ? SzWord : SzByte;
      F3_HU:   sz = we ? SzWord : SzHalf;
      default: sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic funct3_illegal(logic we, logic [2:0] f3);
    logic ill;
    case (funct3_e'(f3))
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic access_err(logic we, logic [2:0] f3, logic [1:0] addr_lo);
    logic mis;
    case (access_size(we, f3))
      SzHalf:  mis = addr_lo[0];
      SzWord:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis | funct3_illegal(we, f3);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes and replicated write data, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  acc_size_e   size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sext;

  assign size = access_size(we_i, funct3_i);

  always_comb begin
    rbyte   = rword_i[{addr_lo_i, 3'b000} +: 8];
    rhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    sext    = ~funct3_i[2];
    wstrb_o = 4'hf;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (size)
      SzByte: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sext & rbyte[7]}}, rbyte};
      end
      SzHalf: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sext & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed-latency response.
// Optional DMEM_ERR_EN flags misaligned/illegal accesses; otherwise rsp_err_o is tied 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  logic [31:0]           mem_q [Words];
  dm_state_e             state_q;
  logic [3:0]            cnt_q;
  logic                  req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]           rsp_rdata_q;
  logic                  accept, acc_err, wr_en;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           rword, wdata_al, rdata_ext;
  logic [3:0]            wstrb;
  logic                  unused_addr;

  assign accept      = req_valid_i & req_ready_q;
  assign widx        = req_addr_i[ADDR_WIDTH+1:2];
  assign rword       = mem_q[widx];
  assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

`ifdef DMEM_ERR_EN
  assign acc_err = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  assign wr_en = accept & req_we_i & ~acc_err;

  dmem_lane_align u_lane_align (
    .we_i      (req_we_i),
    .funct3_i  (req_funct3_i),
    .addr_lo_i (req_addr_i[1:0]),
    .wdata_i   (req_wdata_i),
    .rword_i   (rword),
    .wstrb_o   (wstrb),
    .wdata_o   (wdata_al),
    .rdata_o   (rdata_ext)
  );

  // Storage is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DM_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        DM_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_rdata_q <= (req_we_i | acc_err) ? 32'd0 : rdata_ext;
            rsp_err_q   <= acc_err;
            if (LATENCY == 1) begin
              state_q     <= DM_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= DM_WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        DM_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= DM_RESP;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DM_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= DM_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= DM_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
